// File: rtl/shift_sequencer.sv
// shift_sequencer: runs an N-bit shift as `amount` repeated 1-bit passes
// through an external single-position shifter. Control side uses a
// start/busy/done handshake; the shifter is driven from the working register
// and its combinational result is folded back each SHIFT cycle.
module shift_sequencer #(
  parameter int k     = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amount,
  input  logic [k-1:0]     data_in,
  output logic             busy,
  output logic             done,
  output logic [k-1:0]     data_out,
  output logic [1:0]       sh_code,
  output logic [k-1:0]     sh_data,
  input  logic [k-1:0]     sh_result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [AMT_W-1:0] CNT_ONE  = AMT_W'(1);
  localparam logic [AMT_W-1:0] CNT_ZERO = '0;

  state_t           state;
  logic [1:0]       op_r;
  logic [AMT_W-1:0] cnt;
  logic [k-1:0]     work;

  // Shifter is only asked to move data while a command is in flight;
  // pass code elsewhere keeps its output equal to the working register.
  always_comb begin
    sh_data = work;
    sh_code = (state == SHIFT) ? op_r : 2'b00;
    busy    = (state != IDLE);
    done    = (state == DONE);
  end

  // Command FSM: capture in IDLE, one shifter pass per SHIFT cycle,
  // single-cycle DONE. Reset aborts any command without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      op_r     <= 2'b00;
      cnt      <= CNT_ZERO;
      work     <= '0;
      data_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work <= data_in;
            op_r <= op;
            cnt  <= amount;
            // Zero passes or pass code: result is the operand itself.
            if (amount == CNT_ZERO || op == 2'b00) begin
              data_out <= data_in;
              state    <= DONE;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work <= sh_result;
          cnt  <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            data_out <= sh_result;
            state    <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
